// File: rtl/sr_pair_decoder.sv
// Decoder for an active-low set/reset pair: it samples the pair, filters it for persistence and runs a clocked SR state machine.
// Define SR_DECODER_SYNC_EN to put a two-flop synchronizer in front of the sample register.
module sr_pair_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_n,
    input  logic             r_n,
    input  logic             clear_fault,
    output logic             q,
    output logic             q_n,
    output logic             set_pulse,
    output logic             clr_pulse,
    output logic             fault,
    output logic [CNT_W-1:0] fault_cnt
);
    localparam int              CW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]   HOLD_V = CW'(HOLD_CYCLES);
    localparam logic [1:0]      CMD_SET  = 2'b01;
    localparam logic [1:0]      CMD_RST  = 2'b10;
    localparam logic [1:0]      CMD_IDLE = 2'b11;
    localparam logic [1:0]      CMD_ILL  = 2'b00;

    typedef enum logic [1:0] {ST_HOLD0, ST_HOLD1, ST_FAULT} state_t;

    logic [1:0] pin_pair;

`ifdef SR_DECODER_SYNC_EN
    logic [1:0] raw_pair;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    assign raw_pair = {s_n, r_n};
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_reg[gi] <= 1'b1;
                    sync2_reg[gi] <= 1'b1;
                end else begin
                    sync1_reg[gi] <= raw_pair[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate
    assign pin_pair = sync2_reg;
`else
    assign pin_pair = {s_n, r_n};
`endif

    logic [1:0]       smp_reg;
    logic [1:0]       cmd_prev_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic             cmd_changed;
    logic             accept;
    logic             illegal;

    // The counter saturates at HOLD_CYCLES. A command is accepted only on the
    // cycle where the count first reaches HOLD_CYCLES.
    always_comb begin
        cmd_changed = (smp_reg != cmd_prev_reg);
        if (cmd_changed)
            cnt_next = CW'(1);
        else if (cnt_reg == HOLD_V)
            cnt_next = cnt_reg;
        else
            cnt_next = cnt_reg + CW'(1);
        accept  = (cnt_next == HOLD_V) && (cmd_changed || (cnt_reg != HOLD_V));
        illegal = accept && (smp_reg == CMD_ILL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_reg      <= CMD_IDLE;
            cmd_prev_reg <= CMD_IDLE;
            cnt_reg      <= '0;
        end else begin
            smp_reg      <= pin_pair;
            cmd_prev_reg <= smp_reg;
            cnt_reg      <= cnt_next;
        end
    end

    state_t            state_reg, state_next;
    logic              q_reg, q_next;
    logic              set_pulse_reg, set_pulse_next;
    logic              clr_pulse_reg, clr_pulse_next;
    logic              fault_reg;
    logic [CNT_W-1:0]  fault_cnt_reg, fault_cnt_next;

    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        set_pulse_next = 1'b0;
        clr_pulse_next = 1'b0;
        fault_cnt_next = fault_cnt_reg;
        if (illegal && (fault_cnt_reg != '1))
            fault_cnt_next = fault_cnt_reg + CNT_W'(1);
        case (state_reg)
            ST_HOLD0: begin
                if (illegal)
                    state_next = ST_FAULT;
                else if (accept && (smp_reg == CMD_SET)) begin
                    state_next     = ST_HOLD1;
                    q_next         = 1'b1;
                    set_pulse_next = 1'b1;
                end
            end
            ST_HOLD1: begin
                if (illegal)
                    state_next = ST_FAULT;
                else if (accept && (smp_reg == CMD_RST)) begin
                    state_next     = ST_HOLD0;
                    q_next         = 1'b0;
                    clr_pulse_next = 1'b1;
                end
            end
            ST_FAULT: begin
                // A fresh illegal acceptance beats clear_fault that arrives in the same cycle.
                if (!illegal && clear_fault)
                    state_next = q_reg ? ST_HOLD1 : ST_HOLD0;
            end
            default: state_next = ST_HOLD0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_HOLD0;
            q_reg         <= 1'b0;
            set_pulse_reg <= 1'b0;
            clr_pulse_reg <= 1'b0;
            fault_reg     <= 1'b0;
            fault_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            set_pulse_reg <= set_pulse_next;
            clr_pulse_reg <= clr_pulse_next;
            fault_reg     <= (state_next == ST_FAULT);
            fault_cnt_reg <= fault_cnt_next;
        end
    end

    assign q         = q_reg;
    assign q_n       = ~q_reg;
    assign set_pulse = set_pulse_reg;
    assign clr_pulse = clr_pulse_reg;
    assign fault     = fault_reg;
    assign fault_cnt = fault_cnt_reg;

endmodule

// File: tb/tb_sr_pair_decoder.sv
// Bench for sr_pair_decoder: two instances with HOLD_CYCLES 4 and 1 run side by side. Each is checked against a run-length reference model.
module tb_sr_pair_decoder;
    localparam int CNT_W = 2;
`ifdef SR_DECODER_SYNC_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 1;
`endif
    localparam int HOLD_TAB [2] = '{4, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_n = 1'b1;
    logic r_n = 1'b1;
    logic clear_fault = 1'b0;

    logic [1:0]       q_w, qn_w, sp_w, cp_w, fault_w;
    logic [CNT_W-1:0] fcnt_w [2];

    always #5 clk = ~clk;

    sr_pair_decoder #(.HOLD_CYCLES(4), .CNT_W(CNT_W)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_n(s_n), .r_n(r_n), .clear_fault(clear_fault),
        .q(q_w[0]), .q_n(qn_w[0]), .set_pulse(sp_w[0]), .clr_pulse(cp_w[0]),
        .fault(fault_w[0]), .fault_cnt(fcnt_w[0]));

    sr_pair_decoder #(.HOLD_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_n(s_n), .r_n(r_n), .clear_fault(clear_fault),
        .q(q_w[1]), .q_n(qn_w[1]), .set_pulse(sp_w[1]), .clr_pulse(cp_w[1]),
        .fault(fault_w[1]), .fault_cnt(fcnt_w[1]));

    int vectors = 0;
    int miscompares = 0;

    // Reference model. pipe holds the patterns on their way to the sample point,
    // and each instance tracks the length of the current run of identical samples.
    logic [1:0] pipe [$];
    logic [1:0] m_run_cmd [2];
    int         m_run_len [2];
    logic       m_q [2], m_fault [2], m_sp [2], m_cp [2];
    int         m_fcnt [2];

    task automatic model_edge();
        logic [1:0] cmd;
        logic       acc;
        if (!rst_n) begin
            pipe.delete();
            for (int k = 0; k < DLY; k++) pipe.push_back(2'b11);
            for (int i = 0; i < 2; i++) begin
                m_run_cmd[i] = 2'b11; m_run_len[i] = 0;
                m_q[i] = 0; m_fault[i] = 0; m_sp[i] = 0; m_cp[i] = 0; m_fcnt[i] = 0;
            end
        end else begin
            cmd = pipe[0];
            for (int i = 0; i < 2; i++) begin
                m_sp[i] = 0; m_cp[i] = 0;
                if (cmd == m_run_cmd[i]) m_run_len[i]++;
                else begin m_run_cmd[i] = cmd; m_run_len[i] = 1; end
                acc = (m_run_len[i] == HOLD_TAB[i]);
                if (acc && cmd == 2'b00) begin
                    m_fault[i] = 1;
                    if (m_fcnt[i] < (1 << CNT_W) - 1) m_fcnt[i]++;
                end else if (m_fault[i]) begin
                    if (clear_fault) m_fault[i] = 0;
                end else if (acc && cmd == 2'b01 && !m_q[i]) begin
                    m_q[i] = 1; m_sp[i] = 1;
                end else if (acc && cmd == 2'b10 && m_q[i]) begin
                    m_q[i] = 0; m_cp[i] = 1;
                end
            end
            void'(pipe.pop_front());
            pipe.push_back({s_n, r_n});
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("h%0d_q", HOLD_TAB[i]),     8'(q_w[i]),     8'(m_q[i]));
            chk($sformatf("h%0d_q_n", HOLD_TAB[i]),   8'(qn_w[i]),    8'(!m_q[i]));
            chk($sformatf("h%0d_set", HOLD_TAB[i]),   8'(sp_w[i]),    8'(m_sp[i]));
            chk($sformatf("h%0d_clr", HOLD_TAB[i]),   8'(cp_w[i]),    8'(m_cp[i]));
            chk($sformatf("h%0d_fault", HOLD_TAB[i]), 8'(fault_w[i]), 8'(m_fault[i]));
            chk($sformatf("h%0d_fcnt", HOLD_TAB[i]),  8'(fcnt_w[i]),  8'(m_fcnt[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input logic s, input logic r, input int n);
        s_n = s; r_n = r;
        repeat (n) step();
    endtask

    initial begin
        // Reset, then an idle stretch.
        rst_n = 0;
        repeat (3) step();
        chk("rst_q", 8'(q_w[0]), 8'd0);
        chk("rst_q_n", 8'(qn_w[0]), 8'd1);
        chk("rst_fcnt", 8'(fcnt_w[0]), 8'd0);
        rst_n = 1;
        run(1, 1, 100);
        chk("idle_fault", 8'(fault_w[0]), 8'd0);

        // Set and hold, then reset the latch.
        run(0, 1, 10);
        chk("set_hold_q", 8'(q_w[0]), 8'd1);
        run(1, 0, 10);
        chk("rst_run_q", 8'(q_w[0]), 8'd0);
        run(1, 1, 5);

        // Glitch rejection: three samples are too short for HOLD_CYCLES=4, four are enough.
        run(0, 1, 3);
        run(1, 1, 8);
        chk("glitch3_q", 8'(q_w[0]), 8'd0);
        run(0, 1, 4);
        run(1, 1, 8);
        chk("glitch4_q", 8'(q_w[0]), 8'd1);

        // Illegal pattern, ignored reset, clear, then reset.
        run(0, 0, 6);
        run(1, 1, 4);
        chk("ill_fault", 8'(fault_w[0]), 8'd1);
        chk("ill_fcnt", 8'(fcnt_w[0]), 8'd1);
        run(1, 0, 6);
        chk("fault_q_held", 8'(q_w[0]), 8'd1);
        s_n = 1; r_n = 1; clear_fault = 1;
        step();
        clear_fault = 0;
        chk("cleared", 8'(fault_w[0]), 8'd0);
        run(1, 0, 8);
        chk("post_clear_q", 8'(q_w[0]), 8'd0);
        run(1, 1, 5);

        // Fault counter saturation.
        repeat (5) begin
            run(0, 0, 5);
            run(1, 1, 5);
        end
        chk("sat_fcnt", 8'(fcnt_w[0]), 8'd3);

        // Illegal acceptance on the same edge as clear_fault (HOLD_CYCLES=4 instance).
        run(1, 1, 6);
        s_n = 0; r_n = 0;
        repeat (DLY + 4 - 1) step();
        clear_fault = 1;
        step();
        clear_fault = 0;
        chk("ill_beats_clear", 8'(fault_w[0]), 8'd1);
        run(1, 1, 6);

        // Reset on the second cycle of a SET run, released with s_n still low.
        s_n = 0; r_n = 1;
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        repeat (DLY + 4 - 1) step();
        chk("midrst_early_q", 8'(q_w[0]), 8'd0);
        step();
        chk("midrst_q", 8'(q_w[0]), 8'd1);
        run(1, 1, 6);

        // Random runs with sporadic clear and reset.
        for (int n = 0; n < 150; n++) begin
            logic [1:0] pat;
            int         len;
            pat = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 6);
            s_n = pat[1]; r_n = pat[0];
            for (int c = 0; c < len; c++) begin
                clear_fault = ($urandom_range(0, 7) == 0);
                rst_n       = ($urandom_range(0, 150) != 0);
                step();
            end
        end
        rst_n = 1; clear_fault = 0;
        run(1, 1, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
